// File: rtl/sma_out_pulse_gen.sv
// Avalon-MM slave driving the SMA output: static level, continuous pulse train or counted burst.
// Define SMA_OUT_IRQ_EN to add the irq port and the CTRL.irq_en bit.
`timescale 1ns/1ps
module sma_out_pulse_gen #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_port
`ifdef SMA_OUT_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RUN     = 1'b1;
    localparam logic [1:0] MODE_CONT  = 2'd1;
    localparam logic [1:0] MODE_BURST = 2'd2;

    logic [0:0]       state_q, state_d;
    logic             data_q, data_d;
    logic [1:0]       mode_q, mode_d;
    logic             done_q, done_d;
    logic             start_q, start_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] burst_n_q, burst_n_d;
    logic             burst_run_q, burst_run_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [CNT_W-1:0] period_sh_q, period_sh_d;
    logic [CNT_W-1:0] high_sh_q, high_sh_d;
    logic             out_q, out_d;
    logic [31:0]      readdata_q, readdata_d;

    logic wr_en;
    logic done_set;
    logic done_clr;
    logic busy;
    logic irq_en_bit;
    logic unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign busy         = (state_q == ST_RUN);
    assign unused_wdata = ^writedata;

`ifdef SMA_OUT_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    assign irq_en_bit = irq_en_q;
    assign irq        = irq_q;

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_en && address == 2'd1) begin
            irq_en_d = writedata[5];
        end
        irq_d = done_q & irq_en_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end
`else
    assign irq_en_bit = 1'b0;
`endif

    // Register writes plus the pulse FSM.
    always_comb begin
        data_d      = data_q;
        mode_d      = mode_q;
        period_d    = period_q;
        high_d      = high_q;
        burst_n_d   = burst_n_q;
        start_d     = 1'b0;
        done_clr    = 1'b0;
        done_set    = 1'b0;
        state_d     = state_q;
        burst_run_d = burst_run_q;
        phase_d     = phase_q;
        pulse_cnt_d = pulse_cnt_q;
        period_sh_d = period_sh_q;
        high_sh_d   = high_sh_q;
        out_d       = data_q;

        if (wr_en) begin
            case (address)
                2'd0: data_d = writedata[0];
                2'd1: begin
                    mode_d   = writedata[1:0];
                    // A start that arrives while a run is in progress is dropped here.
                    start_d  = writedata[2] & (state_q == ST_IDLE);
                    done_clr = writedata[4];
                end
                2'd2: begin
                    period_d = writedata[CNT_W-1:0];
                    high_d   = writedata[16 +: CNT_W];
                end
                default: burst_n_d = writedata[CNT_W-1:0];
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                out_d = data_q;
                if (mode_q == MODE_CONT) begin
                    state_d     = ST_RUN;
                    burst_run_d = 1'b0;
                    phase_d     = '0;
                    period_sh_d = period_q;
                    high_sh_d   = high_q;
                end else if (mode_q == MODE_BURST && start_q) begin
                    if (burst_n_q == '0) begin
                        done_set = 1'b1;
                    end else begin
                        state_d     = ST_RUN;
                        burst_run_d = 1'b1;
                        pulse_cnt_d = burst_n_q;
                        phase_d     = '0;
                        period_sh_d = period_q;
                        high_sh_d   = high_q;
                    end
                end
            end
            default: begin
                out_d = (phase_q < high_sh_q);
                // Any mode other than the one the run started in aborts without done.
                if (mode_q != (burst_run_q ? MODE_BURST : MODE_CONT)) begin
                    state_d = ST_IDLE;
                end else if (phase_q == period_sh_q) begin
                    phase_d     = '0;
                    period_sh_d = period_q;
                    high_sh_d   = high_q;
                    if (burst_run_q) begin
                        pulse_cnt_d = pulse_cnt_q - CNT_W'(1);
                        if (pulse_cnt_q == CNT_W'(1)) begin
                            state_d  = ST_IDLE;
                            done_set = 1'b1;
                        end
                    end
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
        endcase

        done_d = done_set | (done_q & ~done_clr);
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0: readdata_d[0] = data_q;
            2'd1: readdata_d[5:0] = {irq_en_bit, done_q, busy, 1'b0, mode_q};
            2'd2: begin
                readdata_d[CNT_W-1:0]  = period_q;
                readdata_d[16 +: CNT_W] = high_q;
            end
            default: readdata_d[CNT_W-1:0] = burst_n_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            data_q      <= 1'b0;
            mode_q      <= 2'd0;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
            period_q    <= '0;
            high_q      <= '0;
            burst_n_q   <= '0;
            burst_run_q <= 1'b0;
            phase_q     <= '0;
            pulse_cnt_q <= '0;
            period_sh_q <= '0;
            high_sh_q   <= '0;
            out_q       <= 1'b0;
            readdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            mode_q      <= mode_d;
            done_q      <= done_d;
            start_q     <= start_d;
            period_q    <= period_d;
            high_q      <= high_d;
            burst_n_q   <= burst_n_d;
            burst_run_q <= burst_run_d;
            phase_q     <= phase_d;
            pulse_cnt_q <= pulse_cnt_d;
            period_sh_q <= period_sh_d;
            high_sh_q   <= high_sh_d;
            out_q       <= out_d;
            readdata_q  <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = out_q;

endmodule

// File: tb/tb_sma_out_pulse_gen.sv
// Bench for sma_out_pulse_gen: register table, scoreboarded pulse patterns and corner sequences.
`timescale 1ns/1ps
module tb_sma_out_pulse_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        out_port;
`ifdef SMA_OUT_IRQ_EN
    logic        irq;
`endif

    sma_out_pulse_gen #(.CNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
`ifdef SMA_OUT_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    vec_t vecs[8];
    sb_t  sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h @%0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%08h @%0t", name, act, $time);
        end
    endtask

    task automatic sb_push(input string name, input logic [31:0] exp);
        sb_t t;
        t.name = name;
        t.exp  = exp;
        sb_q.push_back(t);
    endtask

    task automatic sb_pop(input logic [31:0] act);
        sb_t t;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_underflow: got 0x%08h, want a queued entry", act);
        end else begin
            t = sb_q.pop_front();
            check(t.name, act, t.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'd0;
    endtask

    task automatic drive_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        drive_wr(a, d);
        tick();
        idle_bus();
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        sb_push(name, exp);
        tick();
        sb_pop(readdata);
        idle_bus();
    endtask

    initial begin
        int          highs;
        logic [31:0] ctrl_exp;
        logic        busy_e, done_e, out_e;

        vecs[0] = '{2'd0, 32'hFFFF_FFFF, 32'h0000_0001, "tbl_data_set"};
        vecs[1] = '{2'd0, 32'hFFFF_FFFE, 32'h0000_0000, "tbl_data_clr"};
        vecs[2] = '{2'd2, 32'hABCD_1234, 32'hABCD_1234, "tbl_timing_a"};
        vecs[3] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "tbl_timing_ones"};
        vecs[4] = '{2'd3, 32'hFFFF_0005, 32'h0000_0005, "tbl_burst_n"};
        vecs[5] = '{2'd3, 32'h0000_0000, 32'h0000_0000, "tbl_burst_zero"};
`ifdef SMA_OUT_IRQ_EN
        vecs[6] = '{2'd1, 32'hFFFF_FFEB, 32'h0000_0023, "tbl_ctrl_mode3"};
`else
        vecs[6] = '{2'd1, 32'hFFFF_FFEB, 32'h0000_0003, "tbl_ctrl_mode3"};
`endif
        vecs[7] = '{2'd1, 32'h0000_0000, 32'h0000_0000, "tbl_ctrl_zero"};

        // Reset and read-back of every address
        idle_bus();
        reset_n = 1'b0;
        repeat (3) tick();
        check("rst_out", {31'd0, out_port}, 32'd0);
        check("rst_readdata", readdata, 32'd0);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) rd(a[1:0], 32'd0, "rst_read");

        for (int i = 0; i < 8; i++) begin
            wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end

        // Static level: visible on the second cycle after the strobe
        wr(2'd0, 32'd1);
        check("static_lag", {31'd0, out_port}, 32'd0);
        tick();
        check("static_hi", {31'd0, out_port}, 32'd1);
        wr(2'd0, 32'd0);
        tick();
        check("static_lo", {31'd0, out_port}, 32'd0);

        // Continuous PERIOD=9 HIGH=3; HIGH=5 written mid second period
        wr(2'd2, 32'h0003_0009);
        wr(2'd1, 32'h0000_0001);
        tick();
        for (int c = 0; c < 30; c++) begin
            if (c == 13) drive_wr(2'd2, 32'h0005_0009);
            sb_push($sformatf("cont_c%0d", c), {31'd0, ((c % 10) < ((c < 20) ? 3 : 5))});
            tick();
            sb_pop({31'd0, out_port});
            idle_bus();
        end
        wr(2'd1, 32'h0000_0000);
        tick();
        tick();
        check("cont_stop_out", {31'd0, out_port}, 32'd0);
        rd(2'd1, 32'h0000_0000, "cont_stop_ctrl");

        // Burst PERIOD=4 HIGH=2 N=3
        wr(2'd2, 32'h0002_0004);
        wr(2'd3, 32'd3);
        wr(2'd1, 32'h0000_0006);
        for (int j = 1; j <= 20; j++) begin
            busy_e   = (j >= 2) && (j <= 16);
            done_e   = (j >= 17);
            out_e    = busy_e && (((j - 2) % 5) < 2);
            ctrl_exp = 32'h2 | {27'd0, done_e, busy_e, 3'd0};
            address  = 2'd1;
            sb_push($sformatf("burst_ctrl_j%0d", j), ctrl_exp);
            sb_push($sformatf("burst_out_j%0d", j), {31'd0, out_e});
            tick();
            sb_pop(readdata);
            sb_pop({31'd0, out_port});
        end

        // Start with N=0: done at once, no pulse
        wr(2'd1, 32'h0000_0012);
        wr(2'd3, 32'd0);
        wr(2'd1, 32'h0000_0006);
        rd(2'd1, 32'h0000_0002, "n0_before");
        rd(2'd1, 32'h0000_0012, "n0_done");
        check("n0_out", {31'd0, out_port}, 32'd0);

        // done set (N=0 start) and W1C on the same cycle: set wins
        wr(2'd1, 32'h0000_0006);
        wr(2'd1, 32'h0000_0012);
        rd(2'd1, 32'h0000_0012, "set_wins");

        // Start and BURST write while busy are ignored
        wr(2'd1, 32'h0000_0012);
        wr(2'd3, 32'd3);
        wr(2'd1, 32'h0000_0006);
        highs = 0;
        for (int j = 1; j <= 25; j++) begin
            if (j == 4) drive_wr(2'd3, 32'd1);
            if (j == 6) drive_wr(2'd1, 32'h0000_0006);
            tick();
            idle_bus();
            if (out_port) highs++;
        end
        check("busy_start_highs", highs, 32'd6);
        rd(2'd1, 32'h0000_0012, "busy_start_done");

        // PERIOD=0 boundaries
        wr(2'd1, 32'h0000_0010);
        wr(2'd2, 32'h0000_0000);
        wr(2'd1, 32'h0000_0001);
        tick();
        for (int j = 0; j < 6; j++) begin
            address = 2'd1;
            sb_push("p0_h0_ctrl", 32'h0000_0009);
            sb_push("p0_h0_out", 32'd0);
            tick();
            sb_pop(readdata);
            sb_pop({31'd0, out_port});
        end
        wr(2'd2, 32'h0007_0000);
        tick();
        for (int j = 0; j < 6; j++) begin
            sb_push("p0_h7_out", 32'd1);
            tick();
            sb_pop({31'd0, out_port});
        end
        wr(2'd1, 32'h0000_0000);
        tick();
        tick();
        check("p0_stop_out", {31'd0, out_port}, 32'd0);

        // Mode 0 written mid-burst aborts without done; output returns to DATA
        wr(2'd0, 32'd1);
        wr(2'd2, 32'h0002_0004);
        wr(2'd3, 32'd3);
        wr(2'd1, 32'h0000_0006);
        repeat (6) tick();
        wr(2'd1, 32'h0000_0000);
        tick();
        tick();
        check("abort_out", {31'd0, out_port}, 32'd1);
        rd(2'd1, 32'h0000_0000, "abort_ctrl");

        // Reset mid-burst clears everything
        wr(2'd1, 32'h0000_0006);
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midrst_out", {31'd0, out_port}, 32'd0);
        check("midrst_readdata", readdata, 32'd0);
        for (int a = 0; a < 4; a++) rd(a[1:0], 32'd0, "midrst_read");

`ifdef SMA_OUT_IRQ_EN
        wr(2'd2, 32'h0002_0004);
        wr(2'd3, 32'd2);
        wr(2'd1, 32'h0000_0026);
        for (int j = 1; j <= 14; j++) begin
            sb_push($sformatf("irq_j%0d", j), {31'd0, (j >= 12)});
            tick();
            sb_pop({31'd0, irq});
        end
        wr(2'd1, 32'h0000_0032);
        check("irq_clr_lag", {31'd0, irq}, 32'd1);
        tick();
        check("irq_cleared", {31'd0, irq}, 32'd0);
        wr(2'd3, 32'd0);
        wr(2'd1, 32'h0000_0026);
        wr(2'd1, 32'h0000_0032);
        tick();
        check("irq_set_wins", {31'd0, irq}, 32'd1);
        tick();
        check("irq_set_hold", {31'd0, irq}, 32'd1);
`endif

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_leftover: got %0d entries, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
